// File: rtl/mac_pkg.sv
// Shared types and saturation-limit helpers for the framed MAC engine.
package mac_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } mac_state_e;

  // Limits are returned 64 bits wide; callers keep the low acc_w bits.
  function automatic logic [63:0] sat_max(input int acc_w, input bit sgn);
    if (sgn) return (64'd1 << (acc_w - 1)) - 64'd1;
    else if (acc_w >= 64) return '1;
    else return (64'd1 << acc_w) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int acc_w, input bit sgn);
    if (sgn) return ~((64'd1 << (acc_w - 1)) - 64'd1);
    else return '0;
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Combinational saturating adder: acc + ext_prod clamped to the ACC_W range.
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int ACC_W  = 16,
  parameter int SIGNED = 0
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] ext_prod,
  output logic [ACC_W-1:0] sum,
  output logic             clamped
);

  localparam bit              SGN     = (SIGNED != 0);
  localparam logic [63:0]     MAX64   = sat_max(ACC_W, SGN);
  localparam logic [63:0]     MIN64   = sat_min(ACC_W, SGN);
  localparam logic [ACC_W-1:0] SAT_MAX = MAX64[ACC_W-1:0];
  localparam logic [ACC_W-1:0] SAT_MIN = MIN64[ACC_W-1:0];

  logic [ACC_W:0] wide;
  logic           ovf_pos;
  logic           ovf_neg;

  always_comb begin
    wide = {SGN & acc[ACC_W-1], acc} + {SGN & ext_prod[ACC_W-1], ext_prod};
    // Signed overflow shows as the two top bits of the widened sum disagreeing.
    if (SGN) begin
      ovf_pos = ~wide[ACC_W] & wide[ACC_W-1];
      ovf_neg = wide[ACC_W] & ~wide[ACC_W-1];
    end else begin
      ovf_pos = wide[ACC_W];
      ovf_neg = 1'b0;
    end
    clamped = ovf_pos | ovf_neg;
    if (ovf_pos)      sum = SAT_MAX;
    else if (ovf_neg) sum = SAT_MIN;
    else              sum = wide[ACC_W-1:0];
  end

endmodule

// File: rtl/mac_frame_acc.sv
// Pipelined saturating multiply-accumulate over frames, with a sticky
// saturation flag and a valid/ready result handshake.
module mac_frame_acc
  import mac_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int ACC_W     = 16,
  parameter int SIGNED    = 0,
  parameter int FRAME_LEN = 16
) (
  input  logic             clock,
  input  logic             reset_p,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  a,
  input  logic [IN_W-1:0]  b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             sat_flag
);

  generate
    if (ACC_W < 2 * IN_W) begin : g_bad_acc_w
      $error("mac_frame_acc: ACC_W must be at least 2*IN_W");
    end
    if (FRAME_LEN < 1) begin : g_bad_frame_len
      $error("mac_frame_acc: FRAME_LEN must be at least 1");
    end
  endgenerate

  localparam int              PW       = 2 * IN_W;
  localparam bit              SGN      = (SIGNED != 0);
  localparam int              CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  mac_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_p1_q, vld_p1_d;
  logic             last_p1_q, last_p1_d;
  logic [PW-1:0]    prod_p1_q, prod_p1_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic             out_valid_q, out_valid_d;

  logic [PW-1:0]    a_ext, b_ext, prod;
  logic [ACC_W-1:0] ext_prod, sum;
  logic             clamped;
  logic             accept, last_sample;

  assign in_ready    = (state_q == ACCUM) & ~reset_p;
  assign accept      = in_valid & in_ready;
  assign last_sample = in_last | (cnt_q == CNT_LAST);

  // Low 2*IN_W bits of the product are identical for signed and unsigned
  // once the operands are extended to full width.
  always_comb begin
    a_ext    = {{IN_W{SGN & a[IN_W-1]}}, a};
    b_ext    = {{IN_W{SGN & b[IN_W-1]}}, b};
    prod     = a_ext * b_ext;
    ext_prod = {ACC_W{SGN & prod_p1_q[PW-1]}};
    ext_prod[PW-1:0] = prod_p1_q;
  end

  mac_sat_add #(
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_sat_add (
    .acc      (acc_q),
    .ext_prod (ext_prod),
    .sum      (sum),
    .clamped  (clamped)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vld_p1_d    = 1'b0;
    last_p1_d   = last_p1_q;
    prod_p1_d   = prod_p1_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;

    // Stage 1: register the product of an accepted pair.
    if (accept) begin
      prod_p1_d = prod;
      vld_p1_d  = 1'b1;
      last_p1_d = last_sample;
      cnt_d     = last_sample ? '0 : cnt_q + 1'b1;
      if (last_sample) state_d = DRAIN;
    end

    // Stage 2: saturating accumulate.
    if (vld_p1_q) begin
      acc_d = sum;
      sat_d = sat_q | clamped;
    end

    case (state_q)
      DRAIN: begin
        if (vld_p1_q && last_p1_q) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d       = '0;
          sat_d       = 1'b0;
          cnt_d       = '0;
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset_p) begin
    if (reset_p) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      vld_p1_q    <= 1'b0;
      last_p1_q   <= 1'b0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vld_p1_q    <= vld_p1_d;
      last_p1_q   <= last_p1_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clock) begin
    prod_p1_q <= prod_p1_d;
  end

  assign out_valid = out_valid_q;
  assign acc_out   = acc_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_mac_frame_acc.sv
// Bench for mac_frame_acc: an unsigned and a signed instance share stimulus
// and are compared against a plain-arithmetic frame-sum model.
module tb_mac_frame_acc;

  logic        clock;
  logic        reset_p;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;
  logic [7:0]  a;
  logic [7:0]  b;

  logic        in_ready_u, out_valid_u, sat_u;
  logic [15:0] acc_u;
  logic        in_ready_s, out_valid_s, sat_s;
  logic [15:0] acc_s;

  int checks = 0;
  int errors = 0;

  logic [7:0] fa[4];
  logic [7:0] fb[4];

  mac_frame_acc #(.IN_W(8), .ACC_W(16), .SIGNED(0), .FRAME_LEN(4)) u_dut (
    .clock     (clock),
    .reset_p   (reset_p),
    .in_valid  (in_valid),
    .in_ready  (in_ready_u),
    .a         (a),
    .b         (b),
    .in_last   (in_last),
    .out_valid (out_valid_u),
    .out_ready (out_ready),
    .acc_out   (acc_u),
    .sat_flag  (sat_u)
  );

  mac_frame_acc #(.IN_W(8), .ACC_W(16), .SIGNED(1), .FRAME_LEN(4)) u_dut_s (
    .clock     (clock),
    .reset_p   (reset_p),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s),
    .a         (a),
    .b         (b),
    .in_last   (in_last),
    .out_valid (out_valid_s),
    .out_ready (out_ready),
    .acc_out   (acc_s),
    .sat_flag  (sat_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame sum with a clamp after every addition.
  task automatic model(input bit sgn, input int n, output logic [15:0] acc_e, output logic sat_e);
    longint acc, mx, mn, p;
    acc   = 0;
    sat_e = 1'b0;
    mx    = sgn ? 32767 : 65535;
    mn    = sgn ? -32768 : 0;
    for (int i = 0; i < n; i++) begin
      if (sgn) p = longint'($signed(fa[i])) * longint'($signed(fb[i]));
      else     p = longint'(fa[i]) * longint'(fb[i]);
      acc = acc + p;
      if (acc > mx) begin
        acc = mx;
        sat_e = 1'b1;
      end else if (acc < mn) begin
        acc = mn;
        sat_e = 1'b1;
      end
    end
    acc_e = acc[15:0];
  endtask

  task automatic set_frame(input logic [7:0] a0, input logic [7:0] b0, input logic [7:0] a1,
                           input logic [7:0] b1, input logic [7:0] a2, input logic [7:0] b2,
                           input logic [7:0] a3, input logic [7:0] b3);
    fa[0] = a0; fb[0] = b0; fa[1] = a1; fb[1] = b1;
    fa[2] = a2; fb[2] = b2; fa[3] = a3; fb[3] = b3;
  endtask

  task automatic rand_frame();
    for (int i = 0; i < 4; i++) begin
      case ($urandom_range(0, 3))
        0:       begin fa[i] = 8'hFF; fb[i] = 8'h80; end
        1:       begin fa[i] = 8'h7F; fb[i] = 8'h7F; end
        default: begin fa[i] = 8'($urandom); fb[i] = 8'($urandom); end
      endcase
    end
  endtask

  task automatic do_frame(input int n, input bit use_last, input int hold_cycles);
    logic [15:0] eu, es;
    logic        su, ss;
    model(1'b0, n, eu, su);
    model(1'b1, n, es, ss);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check("in_ready_accum", {31'd0, in_ready_u}, 32'd1);
      a        = fa[i];
      b        = fb[i];
      in_valid = 1'b1;
      in_last  = use_last && (i == n - 1);
    end
    @(negedge clock);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("out_valid_drain", {31'd0, out_valid_u}, 32'd0);
    check("in_ready_drain_u", {31'd0, in_ready_u}, 32'd0);
    check("in_ready_drain_s", {31'd0, in_ready_s}, 32'd0);
    @(negedge clock);
    check("out_valid_u", {31'd0, out_valid_u}, 32'd1);
    check("out_valid_s", {31'd0, out_valid_s}, 32'd1);
    check("acc_u", {16'd0, acc_u}, {16'd0, eu});
    check("sat_u", {31'd0, sat_u}, {31'd0, su});
    check("acc_s", {16'd0, acc_s}, {16'd0, es});
    check("sat_s", {31'd0, sat_s}, {31'd0, ss});
    check("in_ready_hold", {31'd0, in_ready_u}, 32'd0);
    for (int k = 0; k < hold_cycles; k++) begin
      a        = 8'($urandom);
      b        = 8'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      in_last  = 1'($urandom_range(0, 1));
      @(negedge clock);
      check("bp_out_valid", {31'd0, out_valid_u}, 32'd1);
      check("bp_acc_u", {16'd0, acc_u}, {16'd0, eu});
      check("bp_sat_s", {31'd0, sat_s}, {31'd0, ss});
      check("bp_in_ready", {31'd0, in_ready_u}, 32'd0);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check("out_valid_after_hs", {31'd0, out_valid_u}, 32'd0);
    check("in_ready_after_hs", {31'd0, in_ready_u}, 32'd1);
    check("acc_cleared", {16'd0, acc_u}, 32'd0);
    check("sat_cleared", {31'd0, sat_s}, 32'd0);
  endtask

  initial begin
    reset_p   = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clock);
    check("rst_in_ready", {31'd0, in_ready_u}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid_u}, 32'd0);
    check("rst_acc", {16'd0, acc_u}, 32'd0);
    check("rst_sat", {31'd0, sat_u}, 32'd0);
    reset_p = 1'b0;
    #1;
    check("rel_in_ready", {31'd0, in_ready_u}, 32'd1);

    set_frame(8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10);
    do_frame(4, 1'b0, 0);
    set_frame(8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd1, 8'd1);
    do_frame(4, 1'b0, 0);
    set_frame(8'h80, 8'd127, 8'h80, 8'd127, 8'h80, 8'd127, 8'd0, 8'd0);
    do_frame(4, 1'b0, 0);
    set_frame(8'hFD, 8'd5, 8'd2, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0);
    do_frame(2, 1'b1, 0);
    set_frame(8'd3, 8'd4, 8'd5, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0);
    do_frame(2, 1'b1, 0);
    set_frame(8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1);
    do_frame(4, 1'b0, 0);

    rand_frame();
    do_frame(4, 1'b0, 5);
    rand_frame();
    do_frame(4, 1'b1, 0);

    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      a        = 8'd2;
      b        = 8'd2;
      in_valid = 1'b1;
    end
    @(negedge clock);
    in_valid = 1'b0;
    #2 reset_p = 1'b1;
    #1;
    check("midrst_acc", {16'd0, acc_u}, 32'd0);
    check("midrst_sat", {31'd0, sat_u}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid_u}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready_u}, 32'd0);
    @(negedge clock);
    reset_p = 1'b0;
    set_frame(8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1);
    do_frame(4, 1'b0, 0);

    for (int f = 0; f < 10; f++) begin
      int n;
      bit ul;
      n  = $urandom_range(1, 4);
      ul = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      rand_frame();
      do_frame(n, ul, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
